// File: rtl/stepper_cmd_if.sv
// Command bus into the stepper pulse engine: one command (channel, period, count, direction)
// is transferred on any clock where cmd_valid and cmd_ready are both high.
interface stepper_cmd_if #(
    parameter int NUM_CH   = 2,
    parameter int PERIOD_W = 24,
    parameter int COUNT_W  = 16
);
    localparam int CH_W = $clog2(NUM_CH);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [CH_W-1:0]     cmd_ch;
    logic [PERIOD_W-1:0] cmd_period;
    logic [COUNT_W-1:0]  cmd_steps;
    logic                cmd_dir;

    modport master (output cmd_valid, cmd_ch, cmd_period, cmd_steps, cmd_dir,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_ch, cmd_period, cmd_steps, cmd_dir,
                    output cmd_ready);
endinterface

// File: rtl/stepper_multi_pulse_gen.sv
// Multi-channel STEP/DIR pulse engine: each channel runs IDLE -> SETUP -> RUN -> IDLE,
// emitting a counted burst of fixed-width step pulses at a latched, clamped period.
module stepper_multi_pulse_gen #(
    parameter int NUM_CH    = 2,
    parameter int PERIOD_W  = 24,
    parameter int COUNT_W   = 16,
    parameter int PULSE_CYC = 200,
    parameter int DIR_SETUP = 100
) (
    input  logic              clk_100mhz,
    input  logic              rst,
    stepper_cmd_if.slave      cmd,
    input  logic [NUM_CH-1:0] abort,
    output logic [NUM_CH-1:0] step_out,
    output logic [NUM_CH-1:0] step_strobe,
    output logic [NUM_CH-1:0] dir_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);
    localparam int CH_W = $clog2(NUM_CH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Minimum period keeps the low phase at least as long as the high phase.
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * PULSE_CYC);
    localparam logic [PERIOD_W-1:0] SETUP_LAST = PERIOD_W'(DIR_SETUP - 1);
    localparam logic [PERIOD_W-1:0] PULSE_LAST = PERIOD_W'(PULSE_CYC - 1);

    assign cmd.cmd_ready = ~busy[cmd.cmd_ch];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [1:0]          state_q,  state_d;
            logic [PERIOD_W-1:0] cnt_q,    cnt_d;
            logic [PERIOD_W-1:0] period_q, period_d;
            logic [COUNT_W-1:0]  left_q,   left_d;
            logic                step_q,   step_d;
            logic                strobe_q, strobe_d;
            logic                dir_q,    dir_d;
            logic                done_q,   done_d;
            logic                accept;

            // Abort on the same clock as a handshake drops the command.
            assign accept = cmd.cmd_valid && cmd.cmd_ready && !abort[gi] &&
                            (cmd.cmd_ch == CH_W'(gi));

            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q + PERIOD_W'(1);
                period_d = period_q;
                left_d   = left_q;
                step_d   = step_q;
                strobe_d = 1'b0;
                dir_d    = dir_q;
                done_d   = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        cnt_d = '0;
                        if (accept) begin
                            state_d  = ST_SETUP;
                            dir_d    = cmd.cmd_dir;
                            period_d = (cmd.cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd.cmd_period;
                            left_d   = cmd.cmd_steps;
                        end
                    end
                    ST_SETUP: begin
                        if (cnt_q == SETUP_LAST) begin
                            cnt_d = '0;
                            if (left_q == '0) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d  = ST_RUN;
                                step_d   = 1'b1;
                                strobe_d = 1'b1;
                                left_d   = left_q - COUNT_W'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        if (cnt_q == PULSE_LAST) step_d = 1'b0;
                        // left_q counts steps still to issue after the current one.
                        if (cnt_q == period_q - PERIOD_W'(1)) begin
                            cnt_d = '0;
                            if (left_q == '0) begin
                                state_d = ST_IDLE;
                                step_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                step_d   = 1'b1;
                                strobe_d = 1'b1;
                                left_d   = left_q - COUNT_W'(1);
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
                if (abort[gi] && (state_q != ST_IDLE)) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    step_d   = 1'b0;
                    strobe_d = 1'b0;
                    done_d   = 1'b0;
                end
            end

            always_ff @(posedge clk_100mhz) begin
                if (rst) begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    period_q <= '0;
                    left_q   <= '0;
                    step_q   <= 1'b0;
                    strobe_q <= 1'b0;
                    dir_q    <= 1'b0;
                    done_q   <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    cnt_q    <= cnt_d;
                    period_q <= period_d;
                    left_q   <= left_d;
                    step_q   <= step_d;
                    strobe_q <= strobe_d;
                    dir_q    <= dir_d;
                    done_q   <= done_d;
                end
            end

            assign step_out[gi]    = step_q;
            assign step_strobe[gi] = strobe_q;
            assign dir_out[gi]     = dir_q;
            assign busy[gi]        = (state_q != ST_IDLE);
            assign done[gi]        = done_q;
        end
    endgenerate
endmodule

// File: tb/tb_stepper_multi_pulse_gen.sv
// Scoreboard bench: the driver pushes expected step/done event cycles at acceptance; a
// negedge monitor pops them as the DUT presents strobes/done and checks pin levels each cycle.
module tb_stepper_multi_pulse_gen;
    localparam int NUM_CH    = 2;
    localparam int PERIOD_W  = 24;
    localparam int COUNT_W   = 16;
    localparam int PULSE_CYC = 4;
    localparam int DIR_SETUP = 2;

    logic              clk_100mhz = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_CH-1:0] abort_v = '0;
    logic [NUM_CH-1:0] step_out, step_strobe, dir_out, busy, done;

    stepper_cmd_if #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) cmd_bus ();

    stepper_multi_pulse_gen #(
        .NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W),
        .PULSE_CYC(PULSE_CYC), .DIR_SETUP(DIR_SETUP)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .cmd        (cmd_bus),
        .abort      (abort_v),
        .step_out   (step_out),
        .step_strobe(step_strobe),
        .dir_out    (dir_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int cyc = 0;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit mon_en = 0;

    typedef struct { int kind; int at; } ev_t;  // kind 0 = step rise, 1 = done
    ev_t evq [NUM_CH][$];

    // Reference model: per channel, the latest accepted command and when its activity ends.
    int acc_t    [NUM_CH];
    int per_m    [NUM_CH];
    int busy_end [NUM_CH];
    int done_at  [NUM_CH];
    int dir_prev [NUM_CH];
    int dir_new  [NUM_CH];
    int dir_t    [NUM_CH];

    task automatic chk(string nm, int ch, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s ch%0d cyc=%0d got=%0d expected=%0d", nm, ch, cyc, act, exp);
        end
    endtask

    function automatic bit m_busy(int ch, int c);
        return (acc_t[ch] >= 0) && (c > acc_t[ch]) && (c < busy_end[ch]);
    endfunction

    function automatic bit m_step(int ch, int c);
        int first;
        first = acc_t[ch] + 1 + DIR_SETUP;
        if (!m_busy(ch, c) || c < first) return 1'b0;
        return ((c - first) % per_m[ch]) < PULSE_CYC;
    endfunction

    function automatic int m_dir(int ch, int c);
        return (c >= dir_t[ch]) ? dir_new[ch] : dir_prev[ch];
    endfunction

    task automatic prune(int ch, int after);
        ev_t keep[$];
        foreach (evq[ch][i]) if (evq[ch][i].at <= after) keep.push_back(evq[ch][i]);
        evq[ch] = keep;
    endtask

    task automatic model_accept(int ch, int c, int per, int steps, int dir);
        int p;
        p = (per < 2 * PULSE_CYC) ? 2 * PULSE_CYC : per;
        dir_prev[ch] = m_dir(ch, c);
        dir_new[ch]  = dir;
        dir_t[ch]    = c + 1;
        acc_t[ch]    = c;
        per_m[ch]    = p;
        busy_end[ch] = c + 1 + DIR_SETUP + steps * p;
        done_at[ch]  = busy_end[ch];
        for (int k = 0; k < steps; k++) evq[ch].push_back('{0, c + 1 + DIR_SETUP + k * p});
        evq[ch].push_back('{1, done_at[ch]});
    endtask

    task automatic model_abort(int ch, int a);
        if (m_busy(ch, a)) begin
            busy_end[ch] = a + 1;
            if (done_at[ch] > a) done_at[ch] = -1;
            prune(ch, a);
        end
    endtask

    task automatic model_reset(int r);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (busy_end[ch] > r + 1) busy_end[ch] = r + 1;
            if (done_at[ch] > r) done_at[ch] = -1;
            prune(ch, r);
            dir_prev[ch] = m_dir(ch, r);
            dir_new[ch]  = 0;
            dir_t[ch]    = r + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic wait_cyc(int n);
        repeat (n) tick();
    endtask

    task automatic send(int ch, int per, int steps, int dir);
        bit acc;
        int budget;
        acc = 0;
        budget = 0;
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_ch     = ch[0];
        cmd_bus.cmd_period = PERIOD_W'(per);
        cmd_bus.cmd_steps  = COUNT_W'(steps);
        cmd_bus.cmd_dir    = dir[0];
        while (!acc) begin
            if (!m_busy(ch, cyc) && !abort_v[ch]) begin
                model_accept(ch, cyc, per, steps, dir);
                acc = 1;
            end
            tick();
            budget++;
            if (!acc && budget > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout ch%0d cyc=%0d got=held expected=accepted", ch, cyc);
                break;
            end
        end
        cmd_bus.cmd_valid = 1'b0;
        $display("cmd ch%0d period=%0d steps=%0d dir=%0d accepted_at=%0d", ch, per, steps, dir, acc_t[ch]);
    endtask

    task automatic do_abort(int ch);
        abort_v[ch] = 1'b1;
        model_abort(ch, cyc);
        $display("abort ch%0d at cyc=%0d", ch, cyc);
        tick();
        abort_v[ch] = 1'b0;
    endtask

    // Monitor / scoreboard
    initial begin
        ev_t e;
        int  c;
        forever begin
            @(negedge clk_100mhz);
            if (mon_en) begin
                c = cyc;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    chk("busy", ch, int'(busy[ch]), int'(m_busy(ch, c)));
                    chk("step_out", ch, int'(step_out[ch]), int'(m_step(ch, c)));
                    chk("dir_out", ch, int'(dir_out[ch]), m_dir(ch, c));
                    while (evq[ch].size() > 0 && evq[ch][0].at < c) begin
                        e = evq[ch].pop_front();
                        chk("missed_event_cycle", ch, -1, e.at);
                    end
                    if (step_strobe[ch] || done[ch]) begin
                        if (evq[ch].size() == 0) begin
                            chk("unexpected_event_cycle", ch, c, -1);
                        end else begin
                            e = evq[ch].pop_front();
                            chk("event_cycle", ch, c, e.at);
                            chk("event_kind", ch, int'(done[ch]), e.kind);
                            chk("strobe_vs_done", ch, int'(step_strobe[ch]), 1 - e.kind);
                        end
                    end
                end
                chk("cmd_ready", int'(cmd_bus.cmd_ch), int'(cmd_bus.cmd_ready),
                    int'(!m_busy(int'(cmd_bus.cmd_ch), c)));
            end
        end
    end

    initial begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            acc_t[ch] = -1; per_m[ch] = 1; busy_end[ch] = 0; done_at[ch] = -1;
            dir_prev[ch] = 0; dir_new[ch] = 0; dir_t[ch] = 0;
        end
        cmd_bus.cmd_valid  = 1'b0;
        cmd_bus.cmd_ch     = '0;
        cmd_bus.cmd_period = '0;
        cmd_bus.cmd_steps  = '0;
        cmd_bus.cmd_dir    = 1'b0;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        @(negedge clk_100mhz);
        chk("reset_step_out", 0, int'(step_out), 0);
        chk("reset_strobe", 0, int'(step_strobe), 0);
        chk("reset_dir_out", 0, int'(dir_out), 0);
        chk("reset_busy", 0, int'(busy), 0);
        chk("reset_done", 0, int'(done), 0);
        chk("reset_cmd_ready", 0, int'(cmd_bus.cmd_ready), 1);
        mon_en = 1;
        tick();

        // Basic run, period clamp, zero-step command
        send(0, 20, 3, 1);  wait_cyc(70);
        send(1, 3, 2, 0);   wait_cyc(25);
        send(0, 5, 0, 0);   wait_cyc(6);

        // Hold-off on a busy channel while the other channel runs concurrently
        send(0, 10, 3, 1);
        send(1, 8, 2, 1);
        send(0, 8, 1, 0);
        wait_cyc(40);

        // Abort two cycles into the second pulse of a 5-step run
        send(0, 10, 5, 1);
        wait_cyc(14);
        do_abort(0);
        wait_cyc(5);

        // Abort and handshake on the same idle channel in one cycle: command dropped
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_ch     = 1'b0;
        cmd_bus.cmd_period = PERIOD_W'(12);
        cmd_bus.cmd_steps  = COUNT_W'(2);
        cmd_bus.cmd_dir    = 1'b0;
        abort_v[0] = 1'b1;
        model_abort(0, cyc);
        $display("abort+cmd ch0 at cyc=%0d", cyc);
        tick();
        abort_v[0] = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        wait_cyc(8);

        // Reset mid-run on both channels, then a fresh command
        send(0, 20, 3, 1);
        send(1, 10, 4, 0);
        wait_cyc(10);
        rst = 1'b1;
        model_reset(cyc);
        $display("reset at cyc=%0d", cyc);
        tick();
        rst = 1'b0;
        wait_cyc(3);
        send(0, 20, 3, 1);
        wait_cyc(70);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 1)), int'($urandom_range(1, 30)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 1)));
            wait_cyc(int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) do_abort(int'($urandom_range(0, 1)));
        end
        wait_cyc(150);

        for (int ch = 0; ch < NUM_CH; ch++) chk("events_left", ch, evq[ch].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
